// File: rtl/mmio_bridge.sv
// MMIO bridge: decodes CPU requests onto a registered peripheral bus with
// one data-memory slave and one GPIO slave; reads return three cycles after the request.
module mmio_bridge #(
   parameter logic [31:0]  GPIO_BASE  = 32'h1000_0000,
   parameter logic [3:0]   MEM_NIBBLE = 4'h0,
   localparam int unsigned AW         = 32,
   localparam int unsigned DW         = 32,
   localparam int unsigned SW         = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [AW-1:0] cpu_addr,
   input  logic [DW-1:0] cpu_wdata,
   input  logic          cpu_rd_strobe,
   input  logic [SW-1:0] cpu_wr_strobe,
   output logic          cpu_busy,
   output logic [DW-1:0] cpu_rdata,
   output logic          cpu_rvalid,
   output logic          bus_err,
   output logic [AW-1:0] periph_addr,
   output logic [DW-1:0] periph_wdata,
   output logic          mem_rd_strobe,
   output logic          gpio_rd_strobe,
   output logic [SW-1:0] mem_wr_strobe,
   output logic [SW-1:0] gpio_wr_strobe,
   input  logic [DW-1:0] mem_rdata,
   input  logic [DW-1:0] gpio_rdata
);

   typedef enum logic [1:0] {IDLE, WR, RD, RD_CAP} state_t;
   typedef enum logic [1:0] {TGT_NONE, TGT_MEM, TGT_GPIO} tgt_t;

   state_t        state, state_nx;
   tgt_t          tgt, tgt_nx, dec_c;
   logic          req_c;
   logic          busy_nx, rvalid_nx, err_nx;
   logic [DW-1:0] rdata_nx, wdata_nx;
   logic [AW-1:0] addr_nx;
   logic          mem_rd_nx, gpio_rd_nx;
   logic [SW-1:0] mem_wr_nx, gpio_wr_nx;

   // Address decode; the GPIO word wins over the memory window
   always_comb begin
      dec_c = TGT_NONE;
      if (cpu_addr[AW-1:2] == GPIO_BASE[AW-1:2])
         dec_c = TGT_GPIO;
      else if (cpu_addr[AW-1:AW-4] == MEM_NIBBLE)
         dec_c = TGT_MEM;
   end

   assign req_c = cpu_rd_strobe | (|cpu_wr_strobe);

   // Next state and next values of every registered output
   always_comb begin
      state_nx   = state;
      tgt_nx     = tgt;
      addr_nx    = periph_addr;
      wdata_nx   = periph_wdata;
      rdata_nx   = cpu_rdata;
      rvalid_nx  = 1'b0;
      err_nx     = 1'b0;
      mem_rd_nx  = 1'b0;
      gpio_rd_nx = 1'b0;
      mem_wr_nx  = '0;
      gpio_wr_nx = '0;
      case (state)
         IDLE: begin
            if (req_c) begin
               tgt_nx   = dec_c;
               addr_nx  = cpu_addr;
               wdata_nx = cpu_wdata;
               if (cpu_rd_strobe) begin
                  // A read wins over a simultaneous write, which is dropped and flagged
                  state_nx   = RD;
                  mem_rd_nx  = (dec_c == TGT_MEM);
                  gpio_rd_nx = (dec_c == TGT_GPIO);
                  err_nx     = (dec_c == TGT_NONE) | (|cpu_wr_strobe);
               end else begin
                  state_nx   = WR;
                  mem_wr_nx  = (dec_c == TGT_MEM)  ? cpu_wr_strobe : SW'(0);
                  gpio_wr_nx = (dec_c == TGT_GPIO) ? cpu_wr_strobe : SW'(0);
                  err_nx     = (dec_c == TGT_NONE);
               end
            end
         end
         WR:     state_nx = IDLE;
         RD:     state_nx = RD_CAP;
         RD_CAP: begin
            state_nx  = IDLE;
            rvalid_nx = 1'b1;
            case (tgt)
               TGT_MEM:  rdata_nx = mem_rdata;
               TGT_GPIO: rdata_nx = gpio_rdata;
               default:  rdata_nx = '0;
            endcase
         end
         default: state_nx = IDLE;
      endcase
      busy_nx = (state_nx != IDLE);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state          <= IDLE;
         tgt            <= TGT_NONE;
         cpu_busy       <= 1'b0;
         cpu_rdata      <= '0;
         cpu_rvalid     <= 1'b0;
         bus_err        <= 1'b0;
         periph_addr    <= '0;
         periph_wdata   <= '0;
         mem_rd_strobe  <= 1'b0;
         gpio_rd_strobe <= 1'b0;
         mem_wr_strobe  <= '0;
         gpio_wr_strobe <= '0;
      end else begin
         state          <= state_nx;
         tgt            <= tgt_nx;
         cpu_busy       <= busy_nx;
         cpu_rdata      <= rdata_nx;
         cpu_rvalid     <= rvalid_nx;
         bus_err        <= err_nx;
         periph_addr    <= addr_nx;
         periph_wdata   <= wdata_nx;
         mem_rd_strobe  <= mem_rd_nx;
         gpio_rd_strobe <= gpio_rd_nx;
         mem_wr_strobe  <= mem_wr_nx;
         gpio_wr_strobe <= gpio_wr_nx;
      end
   end

endmodule

// File: tb/tb_mmio_bridge.sv
// Bench for mmio_bridge: directed cases plus random traffic, checked through a
// transaction-level reference model and a queue-based scoreboard.
module tb_mmio_bridge;

   localparam logic [31:0] GPIO_BASE  = 32'h1000_0000;
   localparam logic [3:0]  MEM_NIBBLE = 4'h0;
   localparam logic [31:0] GPIO_INIT  = 32'h0BAD_F00D;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [31:0] cpu_addr = '0, cpu_wdata = '0;
   logic        cpu_rd_strobe = 1'b0;
   logic [3:0]  cpu_wr_strobe = '0;
   logic        cpu_busy, cpu_rvalid, bus_err;
   logic [31:0] cpu_rdata, periph_addr, periph_wdata;
   logic        mem_rd_strobe, gpio_rd_strobe;
   logic [3:0]  mem_wr_strobe, gpio_wr_strobe;
   logic [31:0] mem_rdata = '0, gpio_rdata = '0;

   mmio_bridge #(.GPIO_BASE(GPIO_BASE), .MEM_NIBBLE(MEM_NIBBLE)) dut (
      .clk(clk), .rst(rst),
      .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_rd_strobe(cpu_rd_strobe), .cpu_wr_strobe(cpu_wr_strobe),
      .cpu_busy(cpu_busy), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
      .bus_err(bus_err), .periph_addr(periph_addr), .periph_wdata(periph_wdata),
      .mem_rd_strobe(mem_rd_strobe), .gpio_rd_strobe(gpio_rd_strobe),
      .mem_wr_strobe(mem_wr_strobe), .gpio_wr_strobe(gpio_wr_strobe),
      .mem_rdata(mem_rdata), .gpio_rdata(gpio_rdata)
   );

   always #5 clk = ~clk;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] cyc = '0;
   int          busy_left = 0;

   always @(posedge clk) cyc <= cyc + 32'd1;

   typedef struct packed {
      logic [31:0] due;
      logic [10:0] flags;   // mem_rd, gpio_rd, mem_wr[3:0], gpio_wr[3:0], bus_err
      logic [31:0] addr;
      logic [31:0] wdata;
   } bus_exp_t;

   typedef struct packed {
      logic [31:0] due;
      logic [31:0] data;
   } rd_exp_t;

   bus_exp_t txq[$];
   rd_exp_t  rdq[$];

   function automatic logic [31:0] init_word(input logic [29:0] w);
      return {w[15:0] ^ 16'h5A5A, ~w[15:0]};
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                         input logic [3:0] be);
      for (int i = 0; i < 4; i++)
         if (be[i]) old[8*i +: 8] = nw[8*i +: 8];
      return old;
   endfunction

   // Slave models: storage with read data registered one cycle after the strobe
   logic [31:0] mem_store [logic [29:0]];
   logic [31:0] gpio_store = GPIO_INIT;

   always @(posedge clk) begin
      logic [29:0] sw;
      sw = periph_addr[31:2];
      if (mem_wr_strobe != 4'h0)
         mem_store[sw] = merge(mem_store.exists(sw) ? mem_store[sw] : init_word(sw),
                               periph_wdata, mem_wr_strobe);
      if (gpio_wr_strobe != 4'h0)
         gpio_store = merge(gpio_store, periph_wdata, gpio_wr_strobe);
      if (mem_rd_strobe)
         mem_rdata <= mem_store.exists(sw) ? mem_store[sw] : init_word(sw);
      if (gpio_rd_strobe)
         gpio_rdata <= gpio_store;
   end

   // Reference model of the address space as seen by the CPU
   logic [31:0] ref_mem [logic [29:0]];
   logic [31:0] ref_gpio = GPIO_INIT;

   function automatic logic [31:0] model_word(input logic [29:0] w);
      return ref_mem.exists(w) ? ref_mem[w] : init_word(w);
   endfunction

   // Scoreboard monitor
   always @(negedge clk) begin
      bus_exp_t    be;
      rd_exp_t     re;
      logic [10:0] fl;
      fl = {mem_rd_strobe, gpio_rd_strobe, mem_wr_strobe, gpio_wr_strobe, bus_err};
      while (txq.size() != 0 && txq[0].due < cyc) begin
         be = txq.pop_front();
         checks++; errors++;
         $display("FAIL bus_event_missing due=%0d now=%0d exp_flags=%b", be.due, cyc, be.flags);
      end
      while (rdq.size() != 0 && rdq[0].due < cyc) begin
         re = rdq.pop_front();
         checks++; errors++;
         $display("FAIL rvalid_missing due=%0d now=%0d", re.due, cyc);
      end
      if (fl != 11'h0) begin
         checks++;
         if (txq.size() == 0 || txq[0].due != cyc) begin
            errors++;
            $display("FAIL bus_event_unexpected cyc=%0d flags=%b addr=%h", cyc, fl, periph_addr);
         end else begin
            be = txq.pop_front();
            if ({fl, periph_addr, periph_wdata} !== {be.flags, be.addr, be.wdata}) begin
               errors++;
               $display("FAIL bus_event cyc=%0d got flags=%b addr=%h wdata=%h exp flags=%b addr=%h wdata=%h",
                        cyc, fl, periph_addr, periph_wdata, be.flags, be.addr, be.wdata);
            end
         end
      end
      if (cpu_rvalid) begin
         checks++;
         if (rdq.size() == 0 || rdq[0].due != cyc) begin
            errors++;
            $display("FAIL rvalid_unexpected cyc=%0d rdata=%h", cyc, cpu_rdata);
         end else begin
            re = rdq.pop_front();
            if (cpu_rdata !== re.data) begin
               errors++;
               $display("FAIL read_data cyc=%0d got=%h exp=%h", cyc, cpu_rdata, re.data);
            end
         end
      end
   end

   // One cycle slot: check busy against the model, report whether a request will be accepted
   task automatic next_slot(output bit idle);
      @(negedge clk);
      checks++;
      if (cpu_busy !== (busy_left != 0)) begin
         errors++;
         $display("FAIL cpu_busy cyc=%0d got=%b exp=%b", cyc, cpu_busy, busy_left != 0);
      end
      idle = (busy_left == 0);
      if (!idle) busy_left--;
   endtask

   task automatic drive_idle();
      cpu_rd_strobe = 1'b0;
      cpu_wr_strobe = 4'h0;
   endtask

   // Present a request in an idle slot and record what the model says must follow
   task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic rd,
                        input logic [3:0] ws, input bit want_rd);
      bus_exp_t    e;
      rd_exp_t     r;
      int          tg;
      logic [29:0] w;
      w = a[31:2];
      if (a[31:2] == GPIO_BASE[31:2])     tg = 2;
      else if (a[31:28] == MEM_NIBBLE)    tg = 1;
      else                                tg = 0;
      cpu_addr = a; cpu_wdata = d; cpu_rd_strobe = rd; cpu_wr_strobe = ws;
      e.due = cyc + 32'd1; e.addr = a; e.wdata = d;
      if (rd) begin
         e.flags = {tg == 1, tg == 2, 4'h0, 4'h0, (tg == 0) || (ws != 4'h0)};
         r.due   = cyc + 32'd3;
         r.data  = (tg == 0) ? 32'h0 : (tg == 2) ? ref_gpio : model_word(w);
         if (want_rd) rdq.push_back(r);
         busy_left = 2;
      end else begin
         e.flags = {1'b0, 1'b0, (tg == 1) ? ws : 4'h0, (tg == 2) ? ws : 4'h0, tg == 0};
         if (tg == 1)      ref_mem[w] = merge(model_word(w), d, ws);
         else if (tg == 2) ref_gpio   = merge(ref_gpio, d, ws);
         busy_left = 1;
      end
      txq.push_back(e);
   endtask

   // Wait for idle while holding the previous request, then issue
   task automatic send(input logic [31:0] a, input logic [31:0] d, input logic rd,
                       input logic [3:0] ws, input bit want_rd);
      bit idle;
      do next_slot(idle); while (!idle);
      issue(a, d, rd, ws, want_rd);
   endtask

   task automatic rand_issue();
      logic [31:0] a;
      logic [3:0]  ws;
      logic        rd;
      int unsigned sel, kind;
      sel = $urandom_range(9);
      if (sel <= 2)      a = {GPIO_BASE[31:2], 2'($urandom)};
      else if (sel <= 6) a = {MEM_NIBBLE, 18'h0, 10'($urandom)};
      else if (sel == 7) a = {MEM_NIBBLE, 28'($urandom)};
      else if (sel == 8) a = {4'($urandom_range(2, 15)), 28'($urandom)};
      else               a = GPIO_BASE + 32'($urandom_range(1, 3)) * 32'd4;
      kind = $urandom_range(9);
      rd   = (kind <= 3) || (kind == 9);
      ws   = (kind >= 4) ? 4'($urandom_range(1, 15)) : 4'h0;
      issue(a, $urandom, rd, ws, 1'b1);
   endtask

   task automatic check_all_zero(input string tag);
      checks++;
      if ({cpu_busy, cpu_rvalid, bus_err, mem_rd_strobe, gpio_rd_strobe, mem_wr_strobe,
           gpio_wr_strobe, cpu_rdata, periph_addr, periph_wdata} !== 109'h0) begin
         errors++;
         $display("FAIL %s got busy=%b rvalid=%b err=%b strobes=%b%b%h%h rdata=%h addr=%h wdata=%h exp all zero",
                  tag, cpu_busy, cpu_rvalid, bus_err, mem_rd_strobe, gpio_rd_strobe,
                  mem_wr_strobe, gpio_wr_strobe, cpu_rdata, periph_addr, periph_wdata);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL timeout cyc=%0d", cyc);
      $fatal(1, "timeout");
   end

   initial begin
      bit idle;
      // Reset with a request pending: nothing may be accepted
      cpu_addr = GPIO_BASE; cpu_rd_strobe = 1'b1;
      repeat (3) @(negedge clk);
      check_all_zero("reset_state");
      drive_idle();
      rst = 1'b1;

      // Directed: GPIO write/read, unmapped read, rd+wr conflict, back-to-back
      send(32'h1000_0000, 32'h0000_00A5, 1'b0, 4'hF, 1'b1);
      send(32'h1000_0000, 32'h1234_5678, 1'b1, 4'h0, 1'b1);
      send(32'h2000_0000, 32'h0,         1'b1, 4'h0, 1'b1);
      send(32'h0000_0010, 32'hCAFE_0001, 1'b1, 4'hF, 1'b1);
      send(32'h0000_0010, 32'h1111_2222, 1'b1, 4'h0, 1'b1);
      send(32'h0000_0014, 32'hDEAD_BEEF, 1'b0, 4'h5, 1'b1);
      send(32'h0000_0014, 32'h0,         1'b1, 4'h0, 1'b1);
      send(32'h1000_0004, 32'h7777_7777, 1'b0, 4'hF, 1'b1);
      send(32'h1000_0003, 32'h0,         1'b1, 4'h0, 1'b1);
      do next_slot(idle); while (!idle);
      drive_idle();
      repeat (3) next_slot(idle);

      // Random traffic; junk or held requests while busy must be ignored
      for (int i = 0; i < 1500; i++) begin
         next_slot(idle);
         if (idle) begin
            if ($urandom_range(3) != 0) rand_issue();
            else drive_idle();
         end else begin
            case ($urandom_range(2))
               0: drive_idle();
               1: begin
                  cpu_addr      = ($urandom_range(1) == 0) ? GPIO_BASE : {4'h0, 28'($urandom)};
                  cpu_wdata     = $urandom;
                  cpu_rd_strobe = 1'($urandom);
                  cpu_wr_strobe = 4'($urandom);
               end
               default: ;
            endcase
         end
      end
      do next_slot(idle); while (!idle);
      drive_idle();
      repeat (3) next_slot(idle);

      // Reset during RD_CAP aborts the read; a request during reset is dropped
      issue(GPIO_BASE, 32'h0, 1'b1, 4'h0, 1'b0);
      next_slot(idle);
      drive_idle();
      next_slot(idle);
      rst = 1'b0;
      cpu_addr = 32'h0000_0020; cpu_wr_strobe = 4'hF; cpu_wdata = 32'h5555_AAAA;
      @(negedge clk);
      check_all_zero("reset_mid_read");
      @(negedge clk);
      check_all_zero("reset_hold");
      drive_idle();
      rst = 1'b1;
      repeat (5) next_slot(idle);

      checks++;
      if (txq.size() != 0 || rdq.size() != 0) begin
         errors++;
         $display("FAIL pending_expectations got txq=%0d rdq=%0d exp 0 0", txq.size(), rdq.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mmio_bridge.md
MMIO_BRIDGE -- requirements
Module: mmio_bridge

Interface
REQ-001 SHALL have parameter GPIO_BASE, default 32'h1000_0000, word address of the LED GPIO register.
REQ-002 SHALL have parameter MEM_NIBBLE, default 4'h0, value of addr[31:28] selecting data memory.
REQ-003 SHALL use one clock and a synchronous, active-low reset.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  synchronous active-low reset (0 = reset).
REQ-006 cpu_addr  input  32  CPU byte address.
REQ-007 cpu_wdata  input  32  CPU write data.
REQ-008 cpu_rd_strobe  input  1  CPU read request.
REQ-009 cpu_wr_strobe  input  4  CPU byte-write request; any bit set means write.
REQ-010 cpu_busy  output  1  high while the bridge cannot accept a request.
REQ-011 cpu_rdata  output  32  read data, valid when cpu_rvalid is high.
REQ-012 cpu_rvalid  output  1  one-cycle read-complete pulse.
REQ-013 bus_err  output  1  one-cycle pulse on an unmapped or conflicting access.
REQ-014 periph_addr  output  32  registered address to all slaves.
REQ-015 periph_wdata  output  32  registered write data to all slaves.
REQ-016 mem_rd_strobe / gpio_rd_strobe  output  1 each  per-slave read strobe.
REQ-017 mem_wr_strobe / gpio_wr_strobe  output  4 each  per-slave write strobe.
REQ-018 mem_rdata / gpio_rdata  input  32 each  slave read data, registered by the slave one cycle after its rd strobe.

Function
REQ-019 Decode: GPIO selected when addr[31:2]==GPIO_BASE[31:2]; MEM selected when addr[31:28]==MEM_NIBBLE; otherwise unmapped; GPIO match has priority.
REQ-020 FSM states IDLE, WR, RD, RD_CAP; cpu_busy=0 only in IDLE.
REQ-021 IDLE: request accepted at the clock edge when cpu_rd_strobe=1 or |cpu_wr_strobe; cpu_addr, cpu_wdata, strobes and target are registered.
REQ-022 Read accepted -> RD; write-only accepted -> WR; no request -> stay IDLE.
REQ-023 WR (one cycle): selected slave wr strobe = registered cpu_wr_strobe, all other strobes 0; next state IDLE.
REQ-024 RD (one cycle): selected slave rd strobe = 1; next state RD_CAP.
REQ-025 RD_CAP: at the edge, cpu_rdata <= selected slave rdata, cpu_rvalid <= 1, next state IDLE.
REQ-026 Read latency: request edge to cpu_rvalid high = 3 cycles; write occupies bus 1 cycle after acceptance.
REQ-027 Slave strobes SHALL be registered outputs, high only in WR/RD, never for an unmapped target.
REQ-028 periph_addr/periph_wdata hold the last accepted values until the next acceptance.
REQ-029 cpu_rvalid and bus_err are single-cycle pulses, cleared the following cycle.
REQ-030 Simultaneous rd and wr: read performed, write discarded, bus_err pulses in the cycle after acceptance.
REQ-031 Unmapped read: no slave strobe; cpu_rdata=32'h0 with cpu_rvalid at normal latency; bus_err pulses in the cycle after acceptance.
REQ-032 Unmapped write: no strobe issued, WR still taken (busy 1 cycle); bus_err pulses.
REQ-033 Requests presented while cpu_busy=1 SHALL be ignored, not queued.
REQ-034 A new request in the cpu_rvalid cycle (IDLE) SHALL be accepted (back-to-back).

Reset
REQ-035 rst=0 at an edge: state IDLE; cpu_busy, cpu_rvalid, bus_err, all slave strobes = 0; cpu_rdata, periph_addr, periph_wdata = 32'h0.
REQ-036 Reset mid-transaction aborts it; no cpu_rvalid and no further strobe follows.
REQ-037 Requests presented while rst=0 are not accepted.

Verification
REQ-038 Write 32'hA5 to 0x1000_0000, wr 4'hF -> next cycle gpio_wr_strobe=4'hF, periph_wdata=32'hA5, mem strobes 0, cpu_busy=1 for exactly 1 cycle.
REQ-039 Read 0x1000_0000, GPIO model returns 32'hA5 -> gpio_rd_strobe one cycle; cpu_rvalid=1, cpu_rdata=32'hA5 three cycles after request.
REQ-040 Read 0x2000_0000 -> no slave strobe; bus_err pulse; cpu_rvalid with cpu_rdata=32'h0 at cycle 3.
REQ-041 rd=1 and wr=4'hF to 0x0000_0010 -> mem_rd_strobe only, mem_wr_strobe stays 0, bus_err pulse.
REQ-042 rst=0 during RD_CAP -> next cycle all outputs zero, cpu_rvalid never pulses.
REQ-043 Read then write issued in the cpu_rvalid cycle -> write accepted, strobe one cycle later; request held during busy causes no extra transaction.
